mm_master_ctrl: RTL

User-side master RAM controller that sits between `mem_manager` and the HPS/Atom-shared memory bridge. It accepts single-word write commands and 1–24-word read commands. It converts each one into Avalon-MM master transactions and returns the results on the user handshake that `mem_manager` consumes: `read_user_data_available`, `read_user_buffer_output_data` and `write_control_done`. Supported transfers are mailbox-register polls and flag writes (`0x8000000`, `0x8000004`) and 96-byte mine-block reads (`0x8000008`).

---
 rtl/mm_pkg.sv | 19 +
 rtl/mm_master_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the HPS/Atom memory bridge clients: controller FSM states,
// mailbox/mine-block addresses and protocol constants.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } mm_state_t;

    localparam logic [27:0] ATOM_REG      = 28'h8000000;
    localparam logic [27:0] HDWR_REG      = 28'h8000004;
    localparam logic [27:0] MINE_BLOCK    = 28'h8000008;
    localparam logic [27:0] NONCE_BLOCK   = 28'h8000068;
    localparam logic [31:0] ATOM_NEW_DATA = 32'hAAAA0000;
    localparam int          MINE_WORDS    = 24;

endpackage

// File: rtl/mm_master_ctrl.sv
// Avalon-MM master that turns single-word writes and 1..MAX_WORDS-word reads from
// mem_manager into one-outstanding-at-a-time bus transactions with registered outputs.
module mm_master_ctrl
    import mm_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 24,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [4:0]        cmd_length,
    input  logic [DATA_W-1:0] cmd_wrdata,
    output logic              read_user_data_available,
    output logic [DATA_W-1:0] read_user_buffer_output_data,
    output logic              read_user_last,
    output logic              write_control_done,
    output logic              rd_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output mm_state_t         fsm_state
);

    // Handshakes: a command transfers on a cycle with cmd_valid=1 and cmd_ready=1; an
    // Avalon request transfers on a cycle with avm_read/avm_write=1 and avm_waitrequest=0.
    localparam int                TW         = $clog2(TIMEOUT + 1);
    localparam logic [4:0]        MAX_LEN    = 5'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT - 1);

    mm_state_t         state, state_n;
    logic [4:0]        count, count_n, len_eff;
    logic [TW-1:0]     tmo, tmo_n;
    logic              ready_n, rd_n, wr_n, avail_n, last_n, done_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, rdata_n;
    logic [3:0]        be_n;

    assign fsm_state = state;

    always_comb begin
        len_eff  = cmd_length;
        if (cmd_length == 5'd0) len_eff = 5'd1;
        else if (cmd_length > MAX_LEN) len_eff = MAX_LEN;

        state_n = state;
        count_n = count;
        tmo_n   = tmo;
        ready_n = cmd_ready;
        rd_n    = avm_read;
        wr_n    = avm_write;
        addr_n  = avm_address;
        wdata_n = avm_writedata;
        be_n    = avm_byteenable;
        rdata_n = read_user_buffer_output_data;
        avail_n = 1'b0;
        last_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_n  = cmd_address & ALIGN_MASK;
                    ready_n = 1'b0;
                    if (cmd_write) begin
                        wr_n    = 1'b1;
                        wdata_n = cmd_wrdata;
                        be_n    = 4'hF;
                        state_n = WR_REQ;
                    end else begin
                        rd_n    = 1'b1;
                        count_n = len_eff;
                        state_n = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    rd_n    = 1'b0;
                    tmo_n   = '0;
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rdata_n = avm_readdata;
                    avail_n = 1'b1;
                    count_n = count - 5'd1;
                    addr_n  = avm_address + STEP;
                    if (count == 5'd1) begin
                        last_n  = 1'b1;
                        ready_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Next word's request overlaps the data pulse of this one.
                        rd_n    = 1'b1;
                        state_n = RD_REQ;
                    end
                end else if (tmo == TMO_LAST) begin
                    err_n   = 1'b1;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    wr_n    = 1'b0;
                    be_n    = 4'h0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                        <= IDLE;
            count                        <= '0;
            tmo                          <= '0;
            cmd_ready                    <= 1'b1;
            avm_read                     <= 1'b0;
            avm_write                    <= 1'b0;
            avm_address                  <= '0;
            avm_writedata                <= '0;
            avm_byteenable               <= 4'h0;
            read_user_buffer_output_data <= '0;
            read_user_data_available     <= 1'b0;
            read_user_last               <= 1'b0;
            write_control_done           <= 1'b0;
            rd_error                     <= 1'b0;
        end else begin
            state                        <= state_n;
            count                        <= count_n;
            tmo                          <= tmo_n;
            cmd_ready                    <= ready_n;
            avm_read                     <= rd_n;
            avm_write                    <= wr_n;
            avm_address                  <= addr_n;
            avm_writedata                <= wdata_n;
            avm_byteenable               <= be_n;
            read_user_buffer_output_data <= rdata_n;
            read_user_data_available     <= avail_n;
            read_user_last               <= last_n;
            write_control_done           <= done_n;
            rd_error                     <= err_n;
        end
    end

endmodule
